// File: rtl/ibus_wishbone_if_pkg.sv
// Shared types and constants for the instruction-fetch Wishbone bridge.
package ibus_wishbone_if_pkg;

  typedef enum logic [1:0] {
    IBUS_IDLE       = 2'd0,
    IBUS_BUSY       = 2'd1,
    IBUS_WAIT_STALL = 2'd2
  } ibus_state_e;

  localparam logic [3:0] WB_SEL_ALL   = 4'b1111;
  localparam int         STALL_IF_BIT = 1;

endpackage

// File: rtl/ibus_wishbone_if.sv
// Instruction-fetch port to Wishbone B4 classic read master, with IF stall request.
// Optional last-address hit buffer enabled by defining IBUS_LASTHIT_EN.
module ibus_wishbone_if
  import ibus_wishbone_if_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  output logic [DATA_W-1:0]  cpu_data_o,
  output logic               stallreq_o,
  output logic [ADDR_W-1:0]  wb_adr_o,
  input  logic [DATA_W-1:0]  wb_dat_i,
  input  logic               wb_ack_i,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [3:0]         wb_sel_o
);

  ibus_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic [3:0]         sel_q, sel_d;
  logic [DATA_W-1:0]  rd_buf_q, rd_buf_d;
  logic [DATA_W-1:0]  cpu_data;
  logic               stallreq;
  logic               hit;
  logic               unused_stall;

  assign unused_stall = ^stall_i;

`ifdef IBUS_LASTHIT_EN
  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic               last_v_q, last_v_d;

  assign hit = last_v_q && (cpu_addr_i == last_addr_q);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    sel_d    = sel_q;
    rd_buf_d = rd_buf_q;
    cpu_data = '0;
    stallreq = 1'b0;
`ifdef IBUS_LASTHIT_EN
    last_addr_d = last_addr_q;
    last_v_d    = last_v_q;
`endif
    case (state_q)
      IBUS_IDLE: begin
        if (flush_i) begin
`ifdef IBUS_LASTHIT_EN
          last_v_d = 1'b0;
`endif
        end else if (cpu_ce_i) begin
          if (hit) begin
            cpu_data = rd_buf_q;
          end else begin
            stallreq = 1'b1;
            adr_d    = cpu_addr_i;
            cyc_d    = 1'b1;
            stb_d    = 1'b1;
            sel_d    = WB_SEL_ALL;
            state_d  = IBUS_BUSY;
          end
        end
      end
      IBUS_BUSY: begin
        // Flush wins over a same-cycle ack: the fetched word is discarded.
        if (flush_i) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          sel_d    = '0;
          rd_buf_d = '0;
          state_d  = IBUS_IDLE;
`ifdef IBUS_LASTHIT_EN
          last_v_d = 1'b0;
`endif
        end else if (wb_ack_i) begin
          cpu_data = wb_dat_i;
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          sel_d    = '0;
          rd_buf_d = wb_dat_i;
          state_d  = stall_i[STALL_IF_BIT] ? IBUS_WAIT_STALL : IBUS_IDLE;
`ifdef IBUS_LASTHIT_EN
          last_addr_d = adr_q;
          last_v_d    = 1'b1;
`endif
        end else begin
          stallreq = 1'b1;
        end
      end
      IBUS_WAIT_STALL: begin
        cpu_data = rd_buf_q;
        if (flush_i) begin
          rd_buf_d = '0;
          state_d  = IBUS_IDLE;
`ifdef IBUS_LASTHIT_EN
          last_v_d = 1'b0;
`endif
        end else if (!stall_i[STALL_IF_BIT]) begin
          state_d = IBUS_IDLE;
        end
      end
      default: state_d = IBUS_IDLE;
    endcase
    if (rst) begin
      cpu_data = '0;
      stallreq = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IBUS_IDLE;
      adr_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      sel_q    <= '0;
      rd_buf_q <= '0;
`ifdef IBUS_LASTHIT_EN
      last_addr_q <= '0;
      last_v_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      sel_q    <= sel_d;
      rd_buf_q <= rd_buf_d;
`ifdef IBUS_LASTHIT_EN
      last_addr_q <= last_addr_d;
      last_v_q    <= last_v_d;
`endif
    end
  end

  assign cpu_data_o = cpu_data;
  assign stallreq_o = stallreq;
  assign wb_adr_o   = adr_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = 1'b0;

endmodule

// File: tb/tb_ibus_wishbone_if.sv
// Bench for ibus_wishbone_if: directed fetch scenarios then random traffic against a transaction-level model.
module tb_ibus_wishbone_if;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 6;
`ifdef IBUS_LASTHIT_EN
  localparam bit LASTHIT = 1'b1;
`else
  localparam bit LASTHIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] stall_i;
  logic          flush_i;
  logic          cpu_ce_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_data_o;
  logic          stallreq_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [3:0]    wb_sel_o;

  ibus_wishbone_if #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(SW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Transaction-level view: is a read outstanding, is a delivered word being
  // held for a stalled IF stage, and what the last completed fetch was.
  bit          outstanding;
  bit          holding;
  logic [31:0] bus_addr;
  logic [31:0] held_word;
  logic [31:0] last_addr;
  bit          last_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit ce, input logic [31:0] a, input bit f,
                      input logic [5:0] st, input bit ack, input logic [31:0] d);
    logic [31:0] exp_data;
    bit          exp_stall;
    bit          request;
    bit          hit;
    rst = r; cpu_ce_i = ce; cpu_addr_i = a; flush_i = f;
    stall_i = st; wb_ack_i = ack; wb_dat_i = d;
    #3;
    request   = ce && !f;
    hit       = LASTHIT && !outstanding && !holding && request && last_valid && (a == last_addr);
    exp_data  = 32'h0;
    exp_stall = 1'b0;
    if (r) begin
      exp_data = 32'h0;
    end else if (outstanding) begin
      if (f)        exp_data = 32'h0;
      else if (ack) exp_data = d;
      else          exp_stall = 1'b1;
    end else if (holding) begin
      exp_data = held_word;
    end else if (hit) begin
      exp_data = held_word;
    end else begin
      exp_stall = request;
    end
    chk("cpu_data", cpu_data_o, exp_data);
    chk("stallreq", {31'b0, stallreq_o}, {31'b0, exp_stall});
    chk("wb_cyc", {31'b0, wb_cyc_o}, {31'b0, outstanding});
    chk("wb_stb", {31'b0, wb_stb_o}, {31'b0, outstanding});
    chk("wb_sel", {28'b0, wb_sel_o}, outstanding ? 32'hF : 32'h0);
    chk("wb_adr", wb_adr_o, bus_addr);
    chk("wb_we", {31'b0, wb_we_o}, 32'h0);
    @(posedge clk);
    if (r) begin
      outstanding = 0; holding = 0; bus_addr = 0; held_word = 0; last_addr = 0; last_valid = 0;
    end else if (outstanding) begin
      if (f) begin
        outstanding = 0; held_word = 0; last_valid = 0;
      end else if (ack) begin
        outstanding = 0; held_word = d; holding = st[1];
        last_addr = bus_addr; last_valid = 1;
      end
    end else if (holding) begin
      if (f) begin
        holding = 0; held_word = 0; last_valid = 0;
      end else if (!st[1]) begin
        holding = 0;
      end
    end else if (f) begin
      last_valid = 0;
    end else if (request && !hit) begin
      outstanding = 1; bus_addr = a;
    end
    #1;
  endtask

  initial begin
    bit          r, ce, f, ack;
    logic [31:0] a, d;
    logic [5:0]  st;
    rst = 1; stall_i = '0; flush_i = 0; cpu_ce_i = 0; cpu_addr_i = '0;
    wb_dat_i = '0; wb_ack_i = 0;
    outstanding = 0; holding = 0; bus_addr = 0; held_word = 0; last_addr = 0; last_valid = 0;
    @(posedge clk); #1;

    step(1, 0, 32'h0, 0, 6'h00, 0, 32'h0);
    step(1, 1, 32'h0, 0, 6'h00, 0, 32'h0);
    // zero-wait fetch
    step(0, 1, 32'h0000_0000, 0, 6'h00, 0, 32'h0);
    step(0, 0, 32'h0000_0004, 0, 6'h00, 1, 32'h3401_1100);
    step(0, 0, 32'h0000_0004, 0, 6'h00, 0, 32'h0);
    // three wait states while PC toggles
    step(0, 1, 32'h0000_0010, 0, 6'h00, 0, 32'h0);
    step(0, 1, 32'h0000_0004, 0, 6'h00, 0, 32'h0);
    step(0, 1, 32'h0000_0010, 0, 6'h00, 0, 32'h0);
    step(0, 1, 32'h0000_0004, 0, 6'h00, 0, 32'h0);
    step(0, 0, 32'h0000_0004, 0, 6'h00, 1, 32'h1234_5678);
    // ack under IF stall, then held for two cycles
    step(0, 1, 32'h0000_0020, 0, 6'h03, 0, 32'h0);
    step(0, 1, 32'h0000_0024, 0, 6'h03, 1, 32'h1122_3344);
    step(0, 1, 32'h0000_0024, 0, 6'h03, 0, 32'h0);
    step(0, 1, 32'h0000_0024, 0, 6'h03, 0, 32'h0);
    step(0, 1, 32'h0000_0024, 0, 6'h00, 0, 32'h0);
    step(0, 0, 32'h0000_0024, 0, 6'h00, 1, 32'h5555_AAAA);
    // flush with a same-cycle ack, then a late ack
    step(0, 1, 32'h0000_0030, 0, 6'h00, 0, 32'h0);
    step(0, 1, 32'h0000_0030, 1, 6'h00, 1, 32'hDEAD_BEEF);
    step(0, 0, 32'h0000_0030, 0, 6'h00, 1, 32'hDEAD_BEEF);
    step(0, 0, 32'h0000_0030, 0, 6'h00, 0, 32'h0);
    // reset in the middle of a read
    step(0, 1, 32'h0000_0040, 0, 6'h00, 0, 32'h0);
    step(1, 1, 32'h0000_0040, 0, 6'h00, 0, 32'h0);
    step(0, 0, 32'h0000_0040, 0, 6'h00, 0, 32'h0);
    // repeated fetch of the same address, then flush and refetch
    step(0, 1, 32'h0000_0008, 0, 6'h00, 0, 32'h0);
    step(0, 0, 32'h0000_0008, 0, 6'h00, 1, 32'hCAFE_0008);
    step(0, 1, 32'h0000_0008, 0, 6'h00, 0, 32'h0);
    step(0, 0, 32'h0000_0008, 0, 6'h00, 1, 32'hCAFE_0008);
    step(0, 0, 32'h0000_0008, 1, 6'h00, 0, 32'h0);
    step(0, 1, 32'h0000_0008, 0, 6'h00, 0, 32'h0);
    step(0, 0, 32'h0000_0008, 0, 6'h00, 1, 32'hCAFE_0008);

    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      ce  = ($urandom_range(0, 3) != 0);
      a   = {26'b0, 2'($urandom_range(0, 3)), 4'b0000} | 32'h0000_0100;
      f   = ($urandom_range(0, 11) == 0);
      st  = 6'($urandom) & 6'h3D;
      if ($urandom_range(0, 2) == 0) st[1] = 1'b1;
      else st[1] = 1'b0;
      ack = wb_cyc_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      d   = $urandom;
      step(r, ce, a, f, st, ack, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibus_wishbone_if.md
Name: ibus_wishbone_if

Overview:
- Bridges the core's instruction-fetch port (PC address plus chip enable) to a Wishbone B4 classic master bus.
- The fetched instruction is returned to the IF/ID register.
- Sits directly downstream of the processor top-level's instruction-address output and upstream of its instruction-data input, replacing the zero-latency ROM.
- Raises a pipeline stall request while a bus read is outstanding, so the controller freezes PC and IF/ID.

Parameters:
- ADDR_W, 32, instruction address width (matches InstAddrBus).
- DATA_W, 32, instruction width (matches InstBus).
- STALL_W, 6, width of the pipeline stall vector (matches StallBus).

Ports:
- clk  in  1  core clock; every register updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  STALL_W  pipeline stall vector from ctrl; bit 1 = IF stage held.
- flush_i  in  1  abandon the current fetch.
- cpu_ce_i  in  1  fetch enable (PC chip enable).
- cpu_addr_i  in  ADDR_W  fetch address (PC).
- cpu_data_o  out  DATA_W  instruction delivered to IF/ID.
- stallreq_o  out  1  stall request to ctrl, combinational.
- wb_adr_o  out  ADDR_W  Wishbone address, registered.
- wb_dat_i  in  DATA_W  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_cyc_o  out  1  Wishbone cycle, registered.
- wb_stb_o  out  1  Wishbone strobe, registered.
- wb_we_o  out  1  always 0; this block is read-only.
- wb_sel_o  out  4  byte select, registered; 4'b1111 during a cycle, else 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, rd_buf all 0.
  - cpu_data_o=0, stallreq_o=0.
- States: IDLE, BUSY, WAIT_STALL.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: next edge registers wb_adr_o=cpu_addr_i, wb_cyc_o=wb_stb_o=1, wb_sel_o=4'b1111, state->BUSY.
  - stallreq_o=1 combinationally in that same cycle.
  - Otherwise stallreq_o=0.
  - cpu_data_o=0 (NOP).
- BUSY, wb_ack_i=1 (and no flush):
  - cpu_data_o=wb_dat_i combinationally; stallreq_o=0.
  - Next edge: cyc/stb/sel cleared, rd_buf<=wb_dat_i.
  - State->WAIT_STALL if stall_i[1]=1, else IDLE.
- BUSY, wb_ack_i=0: stallreq_o=1, cpu_data_o=0.
- BUSY, address hold: wb_adr_o is held for the whole cycle; changes on cpu_addr_i are ignored until ack.
- BUSY, flush_i=1 (takes priority over ack):
  - Next edge clears cyc/stb/sel and rd_buf, state->IDLE.
  - stallreq_o=0 and cpu_data_o=0 in that cycle.
  - A late ack after abort is ignored, because cyc is low.
- WAIT_STALL:
  - cpu_data_o=rd_buf, stallreq_o=0.
  - stall_i[1]=0 -> IDLE.
  - flush_i=1 -> IDLE and rd_buf<=0.
- Latency with a zero-wait slave: request seen in cycle 0, stb high in cycle 1, ack in cycle 1, instruction delivered in cycle 1. Minimum is 2 cycles per fetch, plus N slave wait cycles.
- Reset mid-transaction: bus is released at that edge, with no completion.
- Wishbone rule: stb never asserts without cyc.

Optional Feature:
- Macro: IBUS_LASTHIT_EN.
- Defined:
  - Keep tag register last_addr plus valid bit last_v, set on every completed ack.
  - In IDLE, a request with cpu_addr_i==last_addr and last_v=1 issues no bus cycle.
  - That hit returns cpu_data_o=rd_buf with stallreq_o=0 in the same cycle.
  - last_v is cleared on reset, flush, and any aborted cycle.
- Undefined: every fetch issues a bus cycle; no tag logic is synthesised.

Decomposition:
- defines.v gains:
  - IBUS_IDLE / IBUS_BUSY / IBUS_WAIT_STALL 2-bit encodings.
  - WB_SEL_ALL=4'b1111.
  - Reuse of existing RstEnable, StallBus, InstBus, InstAddrBus, ZeroWord.
- Single module, no sub-module; the FSM and registers are small enough to stay flat.

Test Plan:
- Reset, then cpu_ce_i=1, addr=0x00000000, slave acks at cycle 1 with 0x34011100 -> wb_adr_o=0, stallreq_o high only in cycle 0, cpu_data_o=0x34011100 in the ack cycle, state IDLE next.
- Slave inserts 3 wait states -> stallreq_o=1 for 4 cycles; wb_adr_o/cyc/stb stable throughout even if cpu_addr_i toggles to 0x4.
- Ack with stall_i=6'b000011 held 2 more cycles -> WAIT_STALL; cpu_data_o=rd_buf for both cycles; no new bus cycle until stall_i[1]=0.
- flush_i=1 in the same cycle as ack, data 0xDEADBEEF -> cpu_data_o=0, rd_buf=0, cyc low next cycle; an ack one cycle later is ignored.
- rst asserted during BUSY -> next edge: cyc/stb/sel=0, state IDLE, all outputs 0.
- IBUS_LASTHIT_EN: fetch 0x8 twice consecutively -> one bus cycle only; second fetch has stallreq_o=0 with identical data. Then flush and refetch 0x8 -> a bus cycle is issued again.
